reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, number of downstream reset domains (legal 1..8).
REQ-002 SHALL have parameter STAGE_DELAY, default 16, cycles between successive stage releases (legal 1..255).
REQ-003 SHALL have parameter LOCK_FILTER, default 8, consecutive synchronized-lock-high cycles required before release starts (legal 1..255).
REQ-004 pll_clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pll_locked  input  1  PLL lock, asynchronous to pll_clk.
REQ-007 soft_req  input  1  level soft-reset request (4-phase with soft_ack).
REQ-008 soft_ack  output  1  soft-reset acknowledge.
REQ-009 stage_rst  output  NUM_STAGES  active-high per-domain resets; bit 0 released first.
REQ-010 ready  output  1  high only while all stages released.
REQ-011 lock_lost  output  1  sticky flag, lock dropped after reaching RUN or RELEASE.

Function
REQ-012 pll_locked SHALL pass through a 2-flop synchronizer (lock_s) before any use.
REQ-013 All outputs SHALL be registered.
REQ-014 FSM states SHALL be WAIT_LOCK, RELEASE, RUN, ASSERT, ACK.
REQ-015 WAIT_LOCK: all stage_rst=1, ready=0; filter counter increments when lock_s=1, clears to 0 when lock_s=0; at counter==LOCK_FILTER-1 with lock_s=1 -> RELEASE, stage index=0, delay counter=0.
REQ-016 RELEASE: delay counter increments each cycle; at counter==STAGE_DELAY-1 SHALL clear stage_rst[index], reset counter to 0, increment index; clearing the last stage SHALL enter RUN and set ready=1 on the same edge.
REQ-017 Stages SHALL release strictly in ascending order, one per STAGE_DELAY cycles; never two on one edge.
REQ-018 RUN: soft_req=1 -> ASSERT, ready=0 on that edge; lock_s=0 takes priority over soft_req.
REQ-019 ASSERT: re-assert one stage per cycle, highest index first; the edge asserting stage_rst[0] SHALL enter ACK and set soft_ack=1.
REQ-020 ACK: all stage_rst=1; soft_ack held until soft_req sampled 0, then soft_ack=0 on that edge and -> WAIT_LOCK with filter counter=0.
REQ-021 Lock loss (lock_s=0) in RELEASE, RUN or ASSERT SHALL set all stage_rst=1, ready=0, lock_lost=1 on the sampling edge and -> WAIT_LOCK.
REQ-022 Lock loss in ACK SHALL NOT break the handshake; it is absorbed by the following WAIT_LOCK filter.
REQ-023 soft_req outside RUN SHALL be ignored; a request still high on reaching RUN SHALL be served.
REQ-024 Counters SHALL be 8 bits and never wrap: cleared on every state change.
REQ-025 lock_lost SHALL clear only on reset.

Reset
REQ-026 reset=1 SHALL asynchronously force state WAIT_LOCK, stage_rst all 1, ready=0, soft_ack=0, lock_lost=0, synchronizer flops 0, all counters 0.
REQ-027 Reset asserted mid-sequence SHALL abort immediately, with no partial release surviving.

Verification (defaults NUM_STAGES=4, STAGE_DELAY=16, LOCK_FILTER=8; edges counted from first rising edge after reset falls)
REQ-028 pll_locked=1 constant -> RELEASE entered at edge 10; stage_rst[0..3] fall at edges 26, 42, 58, 74; ready rises at edge 74; soft_ack=0 and lock_lost=0 throughout.
REQ-029 pll_locked glitches low for 1 cycle at edge 6 -> filter restarts; release delayed accordingly; no stage_rst falls before 8 consecutive lock_s-high cycles.
REQ-030 In RUN, soft_req rises, sampled at edge E -> ready=0 at E; stage_rst[3], [2], [1], [0] rise at E+1..E+4; soft_ack=1 at E+4; soft_req drops at edge F -> soft_ack=0 at F; re-release follows REQ-028 timing relative to F.
REQ-031 In RUN, pll_locked falls -> 3 edges later all stage_rst=1, ready=0, lock_lost=1; lock restored -> full sequence repeats; lock_lost stays 1.
REQ-032 soft_req and lock_s=0 sampled together in RUN -> lock-loss path, soft_ack stays 0; soft_req held -> served after next RUN entry.
REQ-033 reset pulsed between stage 1 and stage 2 release -> all stage_rst=1 asynchronously, and the sequence restarts from WAIT_LOCK.

Source files
------------

// File: rtl/reset_sequencer.sv
// Reset sequencer: filters a PLL lock signal, then releases a set of downstream
// reset domains one at a time in ascending order. Supports a 4-phase soft-reset
// handshake that re-asserts the domains in descending order, and flags lock
// loss after release has started.
//
// Ports:
//   pll_clk_i     sole clock, rising edge
//   reset_i       asynchronous active-high reset
//   pll_locked_i  PLL lock, asynchronous to pll_clk_i (synchronized internally)
//   soft_req_i    level soft-reset request
//   soft_ack_o    soft-reset acknowledge
//   stage_rst_o   active-high per-domain resets, bit 0 released first
//   ready_o       high only while every stage is released
//   lock_lost_o   sticky: lock dropped during RELEASE/RUN/ASSERT
module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 4,  // 1..8
  parameter int unsigned STAGE_DELAY = 16, // 1..255
  parameter int unsigned LOCK_FILTER = 8   // 1..255
) (
  input  logic                  pll_clk_i,
  input  logic                  reset_i,
  input  logic                  pll_locked_i,
  input  logic                  soft_req_i,
  output logic                  soft_ack_o,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic                  ready_o,
  output logic                  lock_lost_o
);

  localparam logic [2:0] StWaitLock = 3'd0;
  localparam logic [2:0] StRelease  = 3'd1;
  localparam logic [2:0] StRun      = 3'd2;
  localparam logic [2:0] StAssert   = 3'd3;
  localparam logic [2:0] StAck      = 3'd4;

  localparam logic [7:0] LockLast  = 8'(LOCK_FILTER - 1);
  localparam logic [7:0] DelayLast = 8'(STAGE_DELAY - 1);
  localparam logic [2:0] LastIdx   = 3'(NUM_STAGES - 1);

  localparam logic [NUM_STAGES-1:0] AllRst = {NUM_STAGES{1'b1}};

  logic                  sync1_q, lock_s_q;
  logic [2:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;   // lock filter or stage delay, per state
  logic [2:0]            idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                  ready_q, ready_d;
  logic                  soft_ack_q, soft_ack_d;
  logic                  lock_lost_q, lock_lost_d;

  // Two-flop synchronizer; nothing downstream looks at pll_locked_i directly.
  always_ff @(posedge pll_clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_locked_i;
      lock_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    stage_rst_d = stage_rst_q;
    ready_d     = ready_q;
    soft_ack_d  = soft_ack_q;
    lock_lost_d = lock_lost_q;

    unique case (state_q)
      StWaitLock: begin
        stage_rst_d = AllRst;
        ready_d     = 1'b0;
        if (!lock_s_q) begin
          cnt_d = 8'd0;
        end else if (cnt_q == LockLast) begin
          state_d = StRelease;
          cnt_d   = 8'd0;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StRelease: begin
        if (!lock_s_q) begin
          state_d     = StWaitLock;
          cnt_d       = 8'd0;
          stage_rst_d = AllRst;
          ready_d     = 1'b0;
          lock_lost_d = 1'b1;
        end else if (cnt_q == DelayLast) begin
          cnt_d = 8'd0;
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx_q == 3'(i)) stage_rst_d[i] = 1'b0;
          end
          if (idx_q == LastIdx) begin
            state_d = StRun;
            ready_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StRun: begin
        // Lock loss wins over a simultaneous soft request.
        if (!lock_s_q) begin
          state_d     = StWaitLock;
          cnt_d       = 8'd0;
          stage_rst_d = AllRst;
          ready_d     = 1'b0;
          lock_lost_d = 1'b1;
        end else if (soft_req_i) begin
          state_d = StAssert;
          cnt_d   = 8'd0;
          idx_d   = LastIdx;
          ready_d = 1'b0;
        end
      end

      StAssert: begin
        if (!lock_s_q) begin
          state_d     = StWaitLock;
          cnt_d       = 8'd0;
          stage_rst_d = AllRst;
          ready_d     = 1'b0;
          lock_lost_d = 1'b1;
        end else begin
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx_q == 3'(i)) stage_rst_d[i] = 1'b1;
          end
          if (idx_q == 3'd0) begin
            state_d    = StAck;
            soft_ack_d = 1'b1;
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end
      end

      StAck: begin
        // Lock is deliberately ignored here; the WAIT_LOCK filter absorbs it.
        stage_rst_d = AllRst;
        ready_d     = 1'b0;
        if (!soft_req_i) begin
          state_d    = StWaitLock;
          cnt_d      = 8'd0;
          soft_ack_d = 1'b0;
        end
      end

      default: begin
        state_d     = StWaitLock;
        cnt_d       = 8'd0;
        idx_d       = 3'd0;
        stage_rst_d = AllRst;
        ready_d     = 1'b0;
        soft_ack_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pll_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StWaitLock;
      cnt_q       <= 8'd0;
      idx_q       <= 3'd0;
      stage_rst_q <= AllRst;
      ready_q     <= 1'b0;
      soft_ack_q  <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stage_rst_q <= stage_rst_d;
      ready_q     <= ready_d;
      soft_ack_q  <= soft_ack_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign stage_rst_o = stage_rst_q;
  assign ready_o     = ready_q;
  assign soft_ack_o  = soft_ack_q;
  assign lock_lost_o = lock_lost_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       sreq;
  logic       sack;
  logic [3:0] srst;
  logic       rdy;
  logic       llost;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_STAGES (4),
    .STAGE_DELAY(16),
    .LOCK_FILTER(8)
  ) dut (
    .pll_clk_i   (clk),
    .reset_i     (rst),
    .pll_locked_i(locked),
    .soft_req_i  (sreq),
    .soft_ack_o  (sack),
    .stage_rst_o (srst),
    .ready_o     (rdy),
    .lock_lost_o (llost)
  );

  // Sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed vector: {stage_rst[3:0], ready, soft_ack, lock_lost}
  function automatic logic [6:0] obs();
    return {srst, rdy, sack, llost};
  endfunction

  // Release model: stage 0 falls at edge 'base', each next one 16 edges later.
  function automatic logic [3:0] rel_stages(int base, int e);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (e < base + 16 * i);
    return r;
  endfunction

  // Holds reset for a few edges, releases it on a falling edge so the next
  // rising edge is edge 1.
  task automatic apply_reset(input logic lock);
    rst    = 1'b1;
    sreq   = 1'b0;
    locked = lock;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] e;
    rst    = 1'b1;
    locked = 1'b1;
    sreq   = 1'b1;
    repeat (3) tick();
    e = 7'b1111_000;
    if (obs() !== e) begin
      $display("FAIL reset_state: got %b expected %b", obs(), e);
      n_fail++;
    end
    n_tests++;
  endtask

  // Constant lock: stage 0..3 fall at edges 26, 42, 58, 74; ready at 74.
  task automatic test_power_up();
    logic [6:0] e;
    apply_reset(1'b1);
    for (int k = 1; k <= 80; k++) begin
      tick();
      e = {rel_stages(26, k), (k >= 74), 1'b0, 1'b0};
      if (obs() !== e) begin
        $display("FAIL power_up edge %0d: got %b expected %b", k, obs(), e);
        n_fail++;
      end
      n_tests++;
    end
  endtask

  // Lock sampled low at edge 6 only: filter restarts, RELEASE at 16, stage 0 at 32.
  task automatic test_glitch();
    logic [6:0] e;
    apply_reset(1'b1);
    for (int k = 1; k <= 85; k++) begin
      tick();
      if (k == 5) locked = 1'b0;
      if (k == 6) locked = 1'b1;
      e = {rel_stages(32, k), (k >= 80), 1'b0, 1'b0};
      if (obs() !== e) begin
        $display("FAIL glitch edge %0d: got %b expected %b", k, obs(), e);
        n_fail++;
      end
      n_tests++;
    end
  endtask

  // Starts in RUN. Descending re-assert, handshake, then re-release from F.
  task automatic test_soft_reset();
    logic [6:0] exp_tbl [7];
    logic [6:0] e;
    exp_tbl[0] = 7'b0000_000; // E: ready drops
    exp_tbl[1] = 7'b1000_000;
    exp_tbl[2] = 7'b1100_000;
    exp_tbl[3] = 7'b1110_000;
    exp_tbl[4] = 7'b1111_010; // E+4: ack
    exp_tbl[5] = 7'b1111_010;
    exp_tbl[6] = 7'b1111_010;
    sreq = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (obs() !== exp_tbl[k]) begin
        $display("FAIL soft_assert E+%0d: got %b expected %b", k, obs(), exp_tbl[k]);
        n_fail++;
      end
      n_tests++;
    end
    sreq = 1'b0;
    tick();
    e = 7'b1111_000;
    if (obs() !== e) begin
      $display("FAIL soft_ack_drop: got %b expected %b", obs(), e);
      n_fail++;
    end
    n_tests++;
    // Synchronizer already high: RELEASE at F+8, stage 0 at F+24, ready at F+72.
    for (int k = 1; k <= 76; k++) begin
      tick();
      e = {rel_stages(24, k), (k >= 72), 1'b0, 1'b0};
      if (obs() !== e) begin
        $display("FAIL soft_rerelease F+%0d: got %b expected %b", k, obs(), e);
        n_fail++;
      end
      n_tests++;
    end
  endtask

  // Starts in RUN. Lock drop seen 3 edges later; recovery re-runs the sequence.
  task automatic test_lock_loss();
    logic [6:0] e;
    locked = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (k == 3) locked = 1'b1;
      if (k < 3) e = 7'b0000_100;
      else       e = {rel_stages(29, k), (k >= 77), 1'b0, 1'b1};
      if (obs() !== e) begin
        $display("FAIL lock_loss X+%0d: got %b expected %b", k, obs(), e);
        n_fail++;
      end
      n_tests++;
    end
  endtask

  // Starts in RUN with lock_lost=1. soft_req and lock loss hit together.
  task automatic test_soft_vs_lock();
    logic [6:0] e;
    locked = 1'b0;
    for (int k = 1; k <= 84; k++) begin
      tick();
      if (k == 2) sreq = 1'b1;
      if (k == 3) locked = 1'b1;
      if (k < 3)       e = 7'b0000_101;
      else if (k < 78) e = {rel_stages(29, k), (k >= 77), 1'b0, 1'b1};
      else if (k == 78) e = 7'b0000_001;  // request served after RUN entry
      else if (k == 79) e = 7'b1000_001;
      else if (k == 80) e = 7'b1100_001;
      else if (k == 81) e = 7'b1110_001;
      else             e = 7'b1111_011;
      if (obs() !== e) begin
        $display("FAIL soft_vs_lock X+%0d: got %b expected %b", k, obs(), e);
        n_fail++;
      end
      n_tests++;
    end
    sreq = 1'b0;
    tick();
    e = 7'b1111_001;
    if (obs() !== e) begin
      $display("FAIL soft_vs_lock_ack_drop: got %b expected %b", obs(), e);
      n_fail++;
    end
    n_tests++;
  endtask

  // Reset pulsed after stage 1 released and before stage 2.
  task automatic test_reset_mid();
    logic [6:0] e;
    apply_reset(1'b1);
    repeat (50) tick();
    e = 7'b1100_000;
    if (obs() !== e) begin
      $display("FAIL reset_mid_pre: got %b expected %b", obs(), e);
      n_fail++;
    end
    n_tests++;
    #2;
    rst = 1'b1;
    #1;
    e = 7'b1111_000;
    if (obs() !== e) begin
      $display("FAIL reset_mid_async: got %b expected %b", obs(), e);
      n_fail++;
    end
    n_tests++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      e = {rel_stages(26, k), 1'b0, 1'b0, 1'b0};
      if (obs() !== e) begin
        $display("FAIL reset_mid_restart edge %0d: got %b expected %b", k, obs(), e);
        n_fail++;
      end
      n_tests++;
    end
  endtask

  initial begin
    rst    = 1'b1;
    locked = 1'b0;
    sreq   = 1'b0;
    test_reset();
    test_power_up();
    test_glitch();
    test_soft_reset();
    test_lock_loss();
    test_soft_vs_lock();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
